// File: rtl/ddr3_bridge_pkg.sv
// Shared types and constants for the cache-FIFO to DDR3 app-interface bridge.
package ddr3_bridge_pkg;
  localparam int LINE_W = 128;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;
endpackage

// File: rtl/ddr3_fifo_bridge_if.sv
// MIG-style DDR3 user (app_*) interface; master = bridge, slave = controller.
interface ddr3_fifo_bridge_if
  import ddr3_bridge_pkg::*;
#(
  parameter int APP_ADDR_W = 28
) ();
  logic [APP_ADDR_W-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [LINE_W-1:0]     app_wdf_data;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;
  logic [LINE_W-1:0]     app_rd_data;
  logic                  app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr3_rd_return_buf.sv
// Read-return FIFO: captures DDR fill data, head is a registered entry so
// a line written this cycle can be drained no earlier than next cycle.
module ddr3_rd_return_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 128,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/ddr3_fifo_bridge.sv
// Drains the cache write (eviction) and read-in (fill) FIFOs onto the DDR3
// app interface and returns fill data into the read-out FIFO.
module ddr3_fifo_bridge
  import ddr3_bridge_pkg::*;
#(
  parameter int APP_ADDR_W   = 28,
  parameter int ADDR_SHIFT   = 1,
  parameter int RD_BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_calib_complete,
  input  logic              wr_fifo_empty,
  input  logic [31:0]       wr_fifo_addr,
  input  logic [LINE_W-1:0] wr_fifo_data,
  output logic              wr_fifo_pop,
  input  logic              rdin_fifo_empty,
  input  logic [31:0]       rdin_fifo_addr,
  output logic              rdin_fifo_pop,
  input  logic              rdout_fifo_full,
  output logic              rdout_fifo_push,
  output logic [LINE_W-1:0] rdout_fifo_data,
  ddr3_fifo_bridge_if.master app,
  output logic              busy,
  output logic              err_unexp_rd
);
  localparam int CW = $clog2(RD_BUF_DEPTH) + 1;

  state_t                  state_q, state_d;
  logic                    en_q, en_d, wren_q, wren_d;
  logic [APP_ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [LINE_W-1:0]       wdata_q, wdata_d;
  logic [CW-1:0]           outstanding_q, outstanding_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           buf_count;
  logic [LINE_W-1:0]       buf_head;
  logic                    rd_acc, ret_ok, buf_pop, credit_ok;

  // Byte address to burst-aligned DRAM column address.
  function automatic logic [APP_ADDR_W-1:0] col_addr(input logic [31:0] a);
    return APP_ADDR_W'((a >> ADDR_SHIFT) & ~32'h7);
  endfunction

  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_count}) < (CW+1)'(RD_BUF_DEPTH);

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    wren_d      = wren_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    wr_fifo_pop = 1'b0;
    rdin_fifo_pop = 1'b0;
    rd_acc      = 1'b0;
    case (state_q)
      IDLE: begin
        // Pops are combinational on FWFT heads; gate with reset so no pop
        // escapes while the block is held in reset.
        if (init_calib_complete && reset) begin
          if (!wr_fifo_empty) begin
            wr_fifo_pop = 1'b1;
            addr_d      = col_addr(wr_fifo_addr);
            cmd_d       = APP_CMD_WRITE;
            wdata_d     = wr_fifo_data;
            en_d        = 1'b1;
            wren_d      = 1'b1;
            state_d     = WR;
          end else if (!rdin_fifo_empty && credit_ok) begin
            rdin_fifo_pop = 1'b1;
            addr_d        = col_addr(rdin_fifo_addr);
            cmd_d         = APP_CMD_READ;
            en_d          = 1'b1;
            state_d       = RD;
          end
        end
      end
      WR: begin
        if (en_q && app.app_rdy)       en_d   = 1'b0;
        if (wren_q && app.app_wdf_rdy) wren_d = 1'b0;
        if (!en_d && !wren_d)          state_d = IDLE;
      end
      RD: begin
        if (app.app_rdy) begin
          en_d    = 1'b0;
          rd_acc  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ret_ok        = app.app_rd_data_valid && (outstanding_q != '0);
    err_d         = err_q || (app.app_rd_data_valid && (outstanding_q == '0));
    outstanding_d = outstanding_q + {{(CW-1){1'b0}}, rd_acc} - {{(CW-1){1'b0}}, ret_ok};
    buf_pop       = (buf_count != '0) && !rdout_fifo_full;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      wren_q        <= 1'b0;
      addr_q        <= '0;
      cmd_q         <= '0;
      wdata_q       <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      wren_q        <= wren_d;
      addr_q        <= addr_d;
      cmd_q         <= cmd_d;
      wdata_q       <= wdata_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  ddr3_rd_return_buf #(
    .DEPTH (RD_BUF_DEPTH),
    .W     (LINE_W)
  ) u_rd_buf (
    .clk       (clk),
    .rst_n     (reset),
    .push      (ret_ok),
    .push_data (app.app_rd_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign app.app_en       = en_q;
  assign app.app_cmd      = cmd_q;
  assign app.app_addr     = addr_q;
  assign app.app_wdf_data = wdata_q;
  assign app.app_wdf_wren = wren_q;
  assign app.app_wdf_end  = wren_q;

  assign rdout_fifo_push = buf_pop;
  assign rdout_fifo_data = buf_head;
  assign busy            = (state_q != IDLE) || (outstanding_q != '0) || (buf_count != '0);
  assign err_unexp_rd    = err_q;
endmodule

// File: tb/tb_ddr3_fifo_bridge.sv
// Directed + randomized bench: behavioural FIFOs, DDR controller stub and a
// line-level scoreboard built from the bridge's external rules.
module tb_ddr3_fifo_bridge;
  localparam int DEPTH = 4;
  localparam logic [127:0] ONE  = 128'd1;
  localparam logic [127:0] ZERO = 128'd0;

  logic         clk = 1'b0;
  logic         reset;
  logic         init_calib_complete;
  logic         wr_fifo_empty, rdin_fifo_empty, rdout_fifo_full;
  logic [31:0]  wr_fifo_addr, rdin_fifo_addr;
  logic [127:0] wr_fifo_data, rdout_fifo_data;
  logic         wr_fifo_pop, rdin_fifo_pop, rdout_fifo_push, busy, err_unexp_rd;

  ddr3_fifo_bridge_if #(.APP_ADDR_W(28)) app_if ();

  ddr3_fifo_bridge #(.APP_ADDR_W(28), .ADDR_SHIFT(1), .RD_BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
    .wr_fifo_empty(wr_fifo_empty), .wr_fifo_addr(wr_fifo_addr), .wr_fifo_data(wr_fifo_data),
    .wr_fifo_pop(wr_fifo_pop), .rdin_fifo_empty(rdin_fifo_empty), .rdin_fifo_addr(rdin_fifo_addr),
    .rdin_fifo_pop(rdin_fifo_pop), .rdout_fifo_full(rdout_fifo_full),
    .rdout_fifo_push(rdout_fifo_push), .rdout_fifo_data(rdout_fifo_data),
    .app(app_if), .busy(busy), .err_unexp_rd(err_unexp_rd)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int rdy_mode, wdf_mode, full_mode, ret_mode;
  bit calib, rand_calib;
  int n_wr_pop, n_rd_pop, n_cmd_wr, n_cmd_rd, n_push;

  logic [31:0]  wq_a[$], rq_a[$];
  logic [127:0] wq_d[$], exp_wd[$], exp_fd[$];
  logic [27:0]  exp_wa[$], exp_ra[$], pend[$];

  logic         s_wr_pop, s_rd_pop, s_en, s_rdy, s_wren, s_wdf_rdy, s_busy, s_push;
  logic [2:0]   s_cmd, p_cmd;
  logic [27:0]  s_addr, p_addr;
  logic [127:0] s_wdata, p_wdata;
  logic         p_en, p_rdy, p_wren, p_wdf_rdy;
  bit           prev_ok;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] app_a(input logic [31:0] a);
    return 28'((a >> 1) & 32'h0FFF_FFF8);
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] aa);
    return {aa, 4'h5, aa ^ 28'h5A5A5A5, 4'hC, {aa[15:0], aa[27:12]}, 32'hC0DE0000 | {4'h0, aa}};
  endfunction

  function automatic logic pick(input int m);
    if (m == 2) return $urandom_range(0, 3) != 0;
    return m == 1;
  endfunction

  // One clock of the environment: drive FIFO/controller models, observe the
  // handshakes that will complete on the coming edge, then advance.
  task automatic cyc();
    logic ret_v, unexp;
    logic [127:0] ret_d;
    if (rand_calib) calib = ($urandom_range(0, 19) != 0);
    init_calib_complete = calib;
    wr_fifo_empty   = (wq_a.size() == 0);
    wr_fifo_addr    = wr_fifo_empty ? 32'h0 : wq_a[0];
    wr_fifo_data    = wr_fifo_empty ? ZERO : wq_d[0];
    rdin_fifo_empty = (rq_a.size() == 0);
    rdin_fifo_addr  = rdin_fifo_empty ? 32'h0 : rq_a[0];
    rdout_fifo_full = (full_mode == 2) ? ($urandom_range(0, 3) == 0) : (full_mode == 1);
    app_if.app_rdy     = pick(rdy_mode);
    app_if.app_wdf_rdy = pick(wdf_mode);
    ret_v = 1'b0; unexp = 1'b0; ret_d = ZERO;
    case (ret_mode)
      1: ret_v = (pend.size() != 0);
      2: ret_v = (pend.size() != 0) && ($urandom_range(0, 1) == 1);
      4: begin ret_v = (pend.size() != 0); ret_mode = 0; end
      5: begin ret_v = 1'b1; unexp = 1'b1; ret_d = {4{32'hDEADBEEF}}; ret_mode = 0; end
      default: ;
    endcase
    if (ret_v && !unexp) ret_d = line_of(pend.pop_front());
    app_if.app_rd_data_valid = ret_v;
    app_if.app_rd_data       = ret_d;
    #1;
    s_wr_pop = wr_fifo_pop;  s_rd_pop = rdin_fifo_pop;
    s_en = app_if.app_en;    s_rdy = app_if.app_rdy;   s_cmd = app_if.app_cmd;
    s_addr = app_if.app_addr; s_wren = app_if.app_wdf_wren; s_wdf_rdy = app_if.app_wdf_rdy;
    s_wdata = app_if.app_wdf_data; s_busy = busy; s_push = rdout_fifo_push;

    if (s_wren) chk("wdf_end", 128'(app_if.app_wdf_end), ONE);
    if (!calib) chk("pop_no_calib", 128'({s_wr_pop, s_rd_pop}), ZERO);
    if (prev_ok) begin
      if (p_en && !p_rdy) begin
        chk("en_hold", 128'(s_en), ONE);
        chk("addr_hold", 128'(s_addr), 128'(p_addr));
        chk("cmd_hold", 128'(s_cmd), 128'(p_cmd));
      end
      if (p_en && p_rdy) chk("en_drop", 128'(s_en), ZERO);
      if (p_wren && !p_wdf_rdy) begin
        chk("wren_hold", 128'(s_wren), ONE);
        chk("wdata_hold", s_wdata, p_wdata);
      end
      if (p_wren && p_wdf_rdy) chk("wren_drop", 128'(s_wren), ZERO);
    end

    if (s_wr_pop) begin
      if (wq_a.size() == 0) chk("wr_pop_empty", ONE, ZERO);
      else begin
        exp_wa.push_back(app_a(wq_a.pop_front()));
        exp_wd.push_back(wq_d.pop_front());
        n_wr_pop++;
      end
    end
    if (s_rd_pop) begin
      if (rq_a.size() == 0) chk("rd_pop_empty", ONE, ZERO);
      else begin
        exp_ra.push_back(app_a(rq_a[0]));
        exp_fd.push_back(line_of(app_a(rq_a.pop_front())));
        n_rd_pop++;
        chk("fill_credit", 128'(exp_fd.size() <= DEPTH), ONE);
      end
    end
    if (s_en && s_rdy) begin
      if (s_cmd == 3'b000) begin
        if (exp_wa.size() == 0) chk("wr_cmd_extra", ONE, ZERO);
        else chk("wr_cmd_addr", 128'(s_addr), 128'(exp_wa.pop_front()));
        n_cmd_wr++;
      end else if (s_cmd == 3'b001) begin
        if (exp_ra.size() == 0) chk("rd_cmd_extra", ONE, ZERO);
        else chk("rd_cmd_addr", 128'(s_addr), 128'(exp_ra.pop_front()));
        pend.push_back(s_addr);
        n_cmd_rd++;
      end else chk("cmd_code", 128'(s_cmd), ZERO);
    end
    if (s_wren && s_wdf_rdy) begin
      if (exp_wd.size() == 0) chk("wdf_extra", ONE, ZERO);
      else chk("wdf_data", s_wdata, exp_wd.pop_front());
    end
    if (s_push) begin
      chk("push_when_full", 128'(rdout_fifo_full), ZERO);
      if (exp_fd.size() == 0) chk("push_extra", ONE, ZERO);
      else chk("fill_data", rdout_fifo_data, exp_fd.pop_front());
      n_push++;
    end
    @(posedge clk); #1;
    app_if.app_rd_data_valid = 1'b0;
    p_en = s_en; p_rdy = s_rdy; p_cmd = s_cmd; p_addr = s_addr;
    p_wren = s_wren; p_wdf_rdy = s_wdf_rdy; p_wdata = s_wdata;
    prev_ok = 1'b1;
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cyc();
      done = (wq_a.size() == 0) && (rq_a.size() == 0) && (exp_wa.size() == 0) &&
             (exp_wd.size() == 0) && (exp_ra.size() == 0) && (exp_fd.size() == 0) &&
             (pend.size() == 0) && !s_busy;
    end
    chk(tag, 128'(done), ONE);
  endtask

  initial begin
    int base_rd, base_push, base_wr;
    reset = 1'b0; calib = 1'b1; rand_calib = 1'b0; prev_ok = 1'b0;
    rdy_mode = 1; wdf_mode = 1; full_mode = 0; ret_mode = 0;
    n_wr_pop = 0; n_rd_pop = 0; n_cmd_wr = 0; n_cmd_rd = 0; n_push = 0;
    init_calib_complete = 1'b1; wr_fifo_empty = 1'b0; rdin_fifo_empty = 1'b0;
    wr_fifo_addr = 32'h40; wr_fifo_data = {4{32'h12345678}}; rdin_fifo_addr = 32'h80;
    rdout_fifo_full = 1'b0;
    app_if.app_rdy = 1'b1; app_if.app_wdf_rdy = 1'b1;
    app_if.app_rd_data_valid = 1'b0; app_if.app_rd_data = ZERO;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with FIFOs non-empty and calibration up.
    chk("rst_wr_pop", 128'(wr_fifo_pop), ZERO);
    chk("rst_rd_pop", 128'(rdin_fifo_pop), ZERO);
    chk("rst_push", 128'(rdout_fifo_push), ZERO);
    chk("rst_en", 128'(app_if.app_en), ZERO);
    chk("rst_wren", 128'(app_if.app_wdf_wren), ZERO);
    chk("rst_end", 128'(app_if.app_wdf_end), ZERO);
    chk("rst_addr", 128'(app_if.app_addr), ZERO);
    chk("rst_busy", 128'(busy), ZERO);
    chk("rst_err", 128'(err_unexp_rd), ZERO);
    reset = 1'b1;

    // Calibration low: nothing issued.
    wq_a.push_back(32'h0000_1230); wq_d.push_back(128'hA5A5_0001_B6B6_0002_C7C7_0003_D8D8_0004);
    rq_a.push_back($urandom());
    calib = 1'b0;
    repeat (4) cyc();
    chk("nocal_wr_pops", 128'(n_wr_pop), ZERO);
    chk("nocal_rd_pops", 128'(n_rd_pop), ZERO);
    chk("nocal_en", 128'(s_en), ZERO);

    // Calibration up: write first; app_rdy low for 3 cycles, wdf_rdy high.
    calib = 1'b1; rdy_mode = 0; wdf_mode = 1;
    cyc();
    chk("prio_wr_pop", 128'(s_wr_pop), ONE);
    chk("prio_rd_pop", 128'(s_rd_pop), ZERO);
    cyc();
    chk("w1_en", 128'(s_en), ONE);
    chk("w1_wren", 128'(s_wren), ONE);
    chk("w1_addr", 128'(s_addr), 128'h918);
    chk("w1_cmd", 128'(s_cmd), ZERO);
    cyc();
    chk("w2_wren", 128'(s_wren), ZERO);
    chk("w2_en", 128'(s_en), ONE);
    cyc();
    chk("w3_en", 128'(s_en), ONE);
    rdy_mode = 1;
    base_wr = n_cmd_wr;
    cyc();
    chk("w4_en", 128'(s_en), ONE);
    chk("w4_cmd_done", 128'(n_cmd_wr - base_wr), ONE);
    cyc();
    chk("w5_en", 128'(s_en), ZERO);
    chk("w5_fill_pop", 128'(s_rd_pop), ONE);
    ret_mode = 1;
    drain("drain_first");

    // Credit limit: six fills with returns withheld.
    ret_mode = 0; rdy_mode = 1; full_mode = 0;
    base_rd = n_cmd_rd; base_push = n_push;
    for (int i = 0; i < 6; i++) rq_a.push_back($urandom());
    repeat (30) cyc();
    chk("credit_4_cmds", 128'(n_cmd_rd - base_rd), 128'd4);
    chk("credit_rdin_left", 128'(rq_a.size()), 128'd2);
    ret_mode = 4;
    repeat (20) cyc();
    chk("credit_5th", 128'(n_cmd_rd - base_rd), 128'd5);
    chk("credit_rdin_left1", 128'(rq_a.size()), ONE);

    // Read-out FIFO full while four returns arrive.
    full_mode = 1; ret_mode = 1;
    repeat (10) cyc();
    chk("full_no_push", 128'(n_push - base_push), ONE);
    chk("full_all_returned", 128'(pend.size()), ZERO);
    full_mode = 0;
    drain("drain_full");
    chk("full_total_push", 128'(n_push - base_push), 128'd6);

    // Read accept and data return in the same cycle.
    ret_mode = 0; rdy_mode = 1;
    base_rd = n_cmd_rd;
    rq_a.push_back($urandom());
    for (int i = 0; i < 20 && n_cmd_rd == base_rd; i++) cyc();
    chk("sim_first_acc", 128'(n_cmd_rd - base_rd), ONE);
    rdy_mode = 0;
    rq_a.push_back($urandom());
    cyc();
    cyc();
    chk("sim_en_wait", 128'(s_en), ONE);
    rdy_mode = 1; ret_mode = 4;
    cyc();
    chk("sim_both", 128'({s_en, s_rdy, app_if.app_rd_data_valid}), 128'd6);
    chk("sim_pend", 128'(pend.size()), ONE);
    ret_mode = 4;
    cyc();
    ret_mode = 0;
    drain("drain_sim");
    chk("sim_no_err", 128'(err_unexp_rd), ZERO);

    // Unexpected return while idle.
    base_push = n_push;
    ret_mode = 5;
    cyc();
    repeat (4) cyc();
    chk("unexp_err", 128'(err_unexp_rd), ONE);
    chk("unexp_no_push", 128'(n_push - base_push), ZERO);
    chk("unexp_busy", 128'(s_busy), ZERO);

    // Reset during a write with app_en held high.
    rdy_mode = 0; wdf_mode = 0;
    wq_a.push_back(32'h0000_2000); wq_d.push_back({4{$urandom()}});
    wq_a.push_back(32'h0000_3000); wq_d.push_back({4{$urandom()}});
    for (int i = 0; i < 10 && !s_en; i++) cyc();
    wr_fifo_empty = 1'b0; init_calib_complete = 1'b1;
    reset = 1'b0;
    #1;
    chk("mid_rst_en", 128'(app_if.app_en), ZERO);
    chk("mid_rst_wren", 128'(app_if.app_wdf_wren), ZERO);
    chk("mid_rst_pops", 128'({wr_fifo_pop, rdin_fifo_pop}), ZERO);
    chk("mid_rst_busy", 128'(busy), ZERO);
    chk("mid_rst_err", 128'(err_unexp_rd), ZERO);
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_fd.delete(); pend.delete();
    prev_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rdy_mode = 1; wdf_mode = 1;
    drain("drain_after_rst");

    // Randomized mixed traffic with back-pressure everywhere.
    rdy_mode = 2; wdf_mode = 2; full_mode = 2; ret_mode = 2; rand_calib = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (wq_a.size() < 3 && $urandom_range(0, 3) == 0) begin
        wq_a.push_back($urandom());
        wq_d.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      end
      if (rq_a.size() < 3 && $urandom_range(0, 2) == 0) rq_a.push_back($urandom());
      cyc();
    end
    rand_calib = 1'b0; calib = 1'b1;
    drain("drain_random");
    chk("final_err", 128'(err_unexp_rd), ZERO);
    chk("final_busy", 128'(busy), ZERO);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
